fetch_unit: RTL and testbench

- Instruction-fetch front end that feeds the single-cycle core's decode/control stage.
- Owns the fetch PC and drives port A of the dual-port memory (synchronous read, 1-cycle latency).
- Buffers fetched bytes in a small prefetch queue and presents whole 1- or 2-byte instructions (opcode + optional immediate) with their address.
- Accepts branch/jump/return redirects from the execute side and a stall from the core.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 52 +++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: opcode length decode,
// queue entry layout and default reset vector.
package fetch_pkg;

    localparam int unsigned PKG_ADDR_W = 8;
    localparam int unsigned PKG_DATA_W = 8;

    localparam logic [3:0]            TWO_BYTE_OPC         = 4'hC;
    localparam logic [PKG_ADDR_W-1:0] DEFAULT_RESET_VECTOR = 8'h00;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] data;
    } q_entry_t;

    // 1 when the opcode carries an immediate byte.
    function automatic logic instr_len(input logic [PKG_DATA_W-1:0] opcode);
        return opcode[PKG_DATA_W-1 -: 4] == TWO_BYTE_OPC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of {addr, data} bytes: push one, pop zero/one/two, flush,
// with the head and the byte behind it exposed for instruction assembly.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  q_entry_t                push_entry,
    input  logic [1:0]              pop_num,
    output logic [$clog2(DEPTH):0]  count,
    output q_entry_t                head,
    output logic [PKG_DATA_W-1:0]   next_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    q_entry_t         mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_nxt;
    logic [PTR_W:0]   count_q;

    assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    assign count      = count_q;
    assign head       = mem_q[rd_ptr_q];
    assign next_data  = mem_q[rd_ptr_nxt].data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop_num);
            count_q  <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop_num);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC/issue to a 1-cycle memory port, prefetch queue,
// 1/2-byte instruction assembly and redirects. FETCH_PERF_EN adds perf counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W       = PKG_ADDR_W,
    parameter int unsigned       DATA_W       = PKG_DATA_W,
    parameter int unsigned       QUEUE_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              stall,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] imm,
    output logic              ir_len,
    output logic [ADDR_W-1:0] ir_pc,
    output logic [ADDR_W-1:0] pc_next_seq
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       bubble_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam int unsigned       CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(QUEUE_DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, ret_addr_q;
    logic              inflight_q, active_q;
    logic [CNT_W-1:0]  q_count, occupancy;
    q_entry_t          head, push_entry;
    logic [DATA_W-1:0] next_data;
    logic              head_len, pop_en;
    logic [1:0]        pop_num;

    // Reserve a slot for the in-flight byte so a return can never overflow the queue.
    assign occupancy  = q_count + CNT_W'(inflight_q);
    assign imem_rd_en = active_q && !redirect_valid && (occupancy < DEPTH_C);
    assign imem_addr  = fetch_pc_q;
    assign push_entry = '{addr: ret_addr_q, data: imem_data};

    assign head_len = instr_len(head.data);
    assign ir_valid = q_count >= (CNT_W'(1) + CNT_W'(head_len));
    assign pop_en   = ir_valid && !stall;
    assign pop_num  = pop_en ? (head_len ? 2'd2 : 2'd1) : 2'd0;

    // A redirect flushes the queue, which also drops the byte returning that cycle;
    // no read is issued during the redirect, so nothing stale can arrive afterwards.
    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (inflight_q),
        .push_entry (push_entry),
        .pop_num    (pop_num),
        .count      (q_count),
        .head       (head),
        .next_data  (next_data)
    );

    always_comb begin
        ir          = '0;
        imm         = '0;
        ir_len      = 1'b0;
        ir_pc       = '0;
        pc_next_seq = '0;
        if (ir_valid) begin
            ir          = head.data;
            imm         = head_len ? next_data : '0;
            ir_len      = head_len;
            ir_pc       = head.addr;
            pc_next_seq = head.addr + ADDR_W'(1) + ADDR_W'(head_len);
        end
    end

    // active_q delays the first issue to the cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_VECTOR;
            ret_addr_q <= '0;
            inflight_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            active_q   <= 1'b1;
            inflight_q <= imem_rd_en;
            if (imem_rd_en) begin
                ret_addr_q <= fetch_pc_q;
            end
            if (redirect_valid) begin
                fetch_pc_q <= redirect_addr;
            end else if (imem_rd_en) begin
                fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (!ir_valid && !stall && bubble_cnt != 16'hFFFF) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
            if (redirect_valid && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: program-order stream model checked every cycle plus
// directed timing checks for reset, stall, redirect, wrap and mid-fetch reset.
module tb_fetch_unit;

    logic       clk;
    logic       rst;
    logic       imem_rd_en;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       redirect_valid;
    logic [7:0] redirect_addr;
    logic       stall;
    logic       ir_valid;
    logic [7:0] ir;
    logic [7:0] imm;
    logic       ir_len;
    logic [7:0] ir_pc;
    logic [7:0] pc_next_seq;
`ifdef FETCH_PERF_EN
    logic [15:0] bubble_cnt;
    logic [15:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic [7:0] exp_pc;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .stall          (stall),
        .ir_valid       (ir_valid),
        .ir             (ir),
        .imm            (imm),
        .ir_len         (ir_len),
        .ir_pc          (ir_pc),
        .pc_next_seq    (pc_next_seq)
`ifdef FETCH_PERF_EN
        ,
        .bubble_cnt     (bubble_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read memory, one cycle of latency.
    always @(posedge clk) begin
        imem_data <= imem_rd_en ? mem[imem_addr] : 8'hEE;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Program-order model: the next instruction must sit at exp_pc, its length
    // and immediate read straight from the memory image.
    always @(negedge clk) begin
        logic [7:0] op;
        logic       len;
        logic [7:0] nsq;
        op  = mem[exp_pc];
        len = (op[7:4] == 4'hC);
        nsq = exp_pc + 8'd1 + {7'd0, len};
        if (!rst) begin
            exp_pc = 8'h00;
            chk("rst_ir_valid", ir_valid, 0);
            chk("rst_rd_en", imem_rd_en, 0);
            chk("rst_imem_addr", imem_addr, 0);
            chk("rst_ir", ir, 0);
            chk("rst_imm", imm, 0);
            chk("rst_ir_pc", ir_pc, 0);
            chk("rst_pc_next_seq", pc_next_seq, 0);
        end else begin
            if (ir_valid) begin
                chk("model_ir_pc", ir_pc, exp_pc);
                chk("model_ir", ir, op);
                chk("model_ir_len", ir_len, len);
                chk("model_imm", imm, len ? mem[exp_pc + 8'd1] : 8'h00);
                chk("model_pc_next_seq", pc_next_seq, nsq);
            end
            if (redirect_valid) exp_pc = redirect_addr;
            else if (ir_valid && !stall) exp_pc = nsq;
        end
    end

    logic [39:0] stall_pat;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = (i < 128) ? 8'(i) : 8'(i - 128);
        mem[8'h00] = 8'h10; mem[8'h01] = 8'h20; mem[8'h02] = 8'hC4; mem[8'h03] = 8'h5A;
        mem[8'h80] = 8'hA5; mem[8'h81] = 8'hC7; mem[8'h82] = 8'h99;
        mem[8'h44] = 8'hC2; mem[8'h45] = 8'h77; mem[8'h48] = 8'hCF;
        mem[8'hFF] = 8'hC1;
        stall_pat = 40'h0F_F000_0F3C;
        exp_pc = 8'h00;
        imem_data = 8'h00;
        stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00;
        rst = 1'b1;
        #2 rst = 1'b0;

        tick(); settle();
        chk("reset_ir_valid", ir_valid, 0);
        chk("reset_rd_en", imem_rd_en, 0);
        tick(); rst = 1'b1;                      // C0
        settle();
        tick(); settle();                        // C1
        chk("c1_rd_en", imem_rd_en, 1);
        chk("c1_addr", imem_addr, 8'h00);
        tick(); settle();                        // C2
        chk("c2_ir_valid", ir_valid, 0);
        chk("c2_addr", imem_addr, 8'h01);
        tick(); settle();                        // C3
        chk("c3_ir_valid", ir_valid, 1);
        chk("c3_ir", ir, 8'h10);
        chk("c3_ir_pc", ir_pc, 8'h00);
        chk("c3_ir_len", ir_len, 0);
        tick(); settle();                        // C4
        chk("c4_ir", ir, 8'h20);
        chk("c4_ir_pc", ir_pc, 8'h01);
        chk("c4_pc_next_seq", pc_next_seq, 8'h02);
        tick(); settle();                        // C5: only the opcode of C4 5A is queued
        chk("c5_partial", ir_valid, 0);
        tick(); settle();                        // C6
        chk("c6_ir", ir, 8'hC4);
        chk("c6_imm", imm, 8'h5A);
        chk("c6_ir_len", ir_len, 1);
        chk("c6_pc_next_seq", pc_next_seq, 8'h04);
        tick(); stall = 1'b1; settle();          // C7
        chk("c7_ir_pc", ir_pc, 8'h04);
        chk("c7_addr", imem_addr, 8'h06);
        chk("c7_rd_en", imem_rd_en, 1);
        tick(); settle();                        // C8
        chk("c8_rd_en", imem_rd_en, 1);
        chk("c8_addr", imem_addr, 8'h07);
        tick(); settle();                        // C9: queue+inflight full
        chk("c9_rd_en", imem_rd_en, 0);
        tick(); settle();
        tick(); settle();
        tick(); settle();                        // C12
        chk("c12_rd_en", imem_rd_en, 0);
        chk("c12_ir", ir, 8'h04);
        chk("c12_ir_pc", ir_pc, 8'h04);
        tick(); stall = 1'b0; settle();          // C13
        chk("c13_ir_valid", ir_valid, 1);
        chk("c13_ir_pc", ir_pc, 8'h04);
        chk("c13_rd_en", imem_rd_en, 0);
        tick(); settle();                        // C14
        chk("c14_ir_pc", ir_pc, 8'h05);
        chk("c14_rd_en", imem_rd_en, 1);
        chk("c14_addr", imem_addr, 8'h08);
        tick(); settle();
        tick(); settle();
        tick(); stall = 1'b1; settle();          // C17
        chk("c17_ir_pc", ir_pc, 8'h08);
        tick(); settle();                        // C18: 3 queued, 1 in flight
        chk("c18_rd_en", imem_rd_en, 0);
        chk("c18_ir_valid", ir_valid, 1);
        tick(); redirect_valid = 1'b1; redirect_addr = 8'h80; settle();
        chk("redir_cycle_rd_en", imem_rd_en, 0);
        tick(); redirect_valid = 1'b0; stall = 1'b0; settle();
        chk("redir_p1_ir_valid", ir_valid, 0);
        chk("redir_p1_rd_en", imem_rd_en, 1);
        chk("redir_p1_addr", imem_addr, 8'h80);
        tick(); settle();
        chk("redir_p2_ir_valid", ir_valid, 0);
        tick(); settle();
        chk("redir_p3_ir_valid", ir_valid, 1);
        chk("redir_p3_ir_pc", ir_pc, 8'h80);
        chk("redir_p3_ir", ir, 8'hA5);
        chk("model_pc_pin", exp_pc, 8'h80);
        tick(); settle();
        chk("redir_p4_partial", ir_valid, 0);
        tick(); settle();
        chk("redir_p5_ir", ir, 8'hC7);
        chk("redir_p5_imm", imm, 8'h99);
        chk("redir_p5_nsq", pc_next_seq, 8'h83);

        // Wrap: 2-byte opcode at FF takes its immediate from 00.
        tick(); redirect_valid = 1'b1; redirect_addr = 8'hFF; mem[8'h00] = 8'h33; settle();
        tick(); redirect_valid = 1'b0; settle();
        chk("wrap_addr_ff", imem_addr, 8'hFF);
        tick(); settle();
        chk("wrap_addr_00", imem_addr, 8'h00);
        tick(); settle();
        chk("wrap_partial", ir_valid, 0);
        tick(); settle();
        chk("wrap_ir", ir, 8'hC1);
        chk("wrap_imm", imm, 8'h33);
        chk("wrap_ir_pc", ir_pc, 8'hFF);
        chk("wrap_nsq", pc_next_seq, 8'h01);

        // Reset while a 2-byte instruction at FF is only half fetched.
        tick(); redirect_valid = 1'b1; redirect_addr = 8'hFF; settle();
        tick(); redirect_valid = 1'b0; settle();
        tick(); settle();
        tick(); settle();
        chk("pre_rst_partial", ir_valid, 0);
        tick(); rst = 1'b0; mem[8'h00] = 8'h10; settle();
        chk("mid_rst_ir_valid", ir_valid, 0);
        chk("mid_rst_rd_en", imem_rd_en, 0);
        chk("mid_rst_addr", imem_addr, 8'h00);
        tick(); settle();
        tick(); rst = 1'b1; settle();
        tick(); settle();
        chk("restart_rd_en", imem_rd_en, 1);
        chk("restart_addr", imem_addr, 8'h00);
        tick(); settle();
        tick(); settle();
        chk("restart_ir", ir, 8'h10);
        chk("restart_ir_pc", ir_pc, 8'h00);

        // Free run with a fixed stall pattern and one redirect; the model checks it.
        for (int i = 0; i < 40; i++) begin
            tick();
            stall = stall_pat[i];
            redirect_valid = (i == 20);
            redirect_addr = 8'h40;
            settle();
            if (i == 23) begin
                chk("run_redir_ir_valid", ir_valid, 1);
                chk("run_redir_ir_pc", ir_pc, 8'h40);
            end
        end
        tick();
        stall = 1'b0;
        redirect_valid = 1'b0;
        repeat (20) begin
            tick();
            settle();
        end
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
